// File: rtl/tdc_edge_decoder.sv
// Fine-time decoder: finds the earliest rising edge in an ISERDES word and timestamps it.
// Latency: hit_valid one cycle after the sampled word; timestamp fields hold until the next hit.
// Backpressure: none; edges arriving while idle or in dead time are dropped.
//
// Ports:
//   clk100, rst        sole clock, synchronous active-high reset
//   iser_bits          sample word, bit 0 earliest in time
//   arm                arms the decoder while idle
//   hit_valid          one-cycle strobe, hit_coarse/hit_fine valid
//   hit_coarse         coarse count of the cycle the edge was sampled in
//   hit_fine           bit index of the earliest edge
//   coarse_wrap        one-cycle strobe when the coarse counter reads 0 after rollover
//   busy               armed or in dead time
//   hit_count          accepted hits since reset, saturating
module tdc_edge_decoder #(
  parameter int SER_W       = 4,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 2,
  parameter int CONTINUOUS  = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic [SER_W-1:0]         iser_bits,
  input  logic                     arm,
  output logic                     hit_valid,
  output logic [COARSE_W-1:0]      hit_coarse,
  output logic [$clog2(SER_W)-1:0] hit_fine,
  output logic                     coarse_wrap,
  output logic                     busy,
  output logic [CNT_W-1:0]         hit_count
);

  localparam int FINE_W = $clog2(SER_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t              state;
  logic                prev_last;
  logic [COARSE_W-1:0] coarse;
  logic [7:0]          dead_cnt;

  logic [SER_W-1:0]    edge_vec;
  logic [FINE_W-1:0]   edge_fine;
  logic                edge_found;

  // Each bit is compared with the sample just before it in time; bit 0 looks
  // back across the word boundary to the last sample of the previous word.
  always_comb begin
    edge_vec   = iser_bits & ~{iser_bits[SER_W-2:0], prev_last};
    edge_found = |edge_vec;
    edge_fine  = '0;
    // Scan from the top so the lowest (earliest) set bit wins.
    for (int i = SER_W - 1; i >= 0; i--) begin
      if (edge_vec[i]) begin
        edge_fine = FINE_W'(i);
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state       <= ST_IDLE;
      prev_last   <= 1'b1;  // a line already high at reset must not look like an edge
      coarse      <= '0;
      dead_cnt    <= '0;
      hit_valid   <= 1'b0;
      hit_coarse  <= '0;
      hit_fine    <= '0;
      coarse_wrap <= 1'b0;
      busy        <= 1'b0;
      hit_count   <= '0;
    end else begin
      prev_last   <= iser_bits[SER_W-1];
      coarse      <= coarse + COARSE_W'(1);
      coarse_wrap <= (coarse == '1);
      hit_valid   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end

        ST_ARMED: begin
          if (edge_found) begin
            hit_valid  <= 1'b1;
            hit_coarse <= coarse;
            hit_fine   <= edge_fine;
            state      <= ST_DEAD;
            dead_cnt   <= 8'(DEAD_CYCLES);
            if (hit_count != '1) begin
              hit_count <= hit_count + CNT_W'(1);
            end
          end
        end

        ST_DEAD: begin
          // Leaving on the count of 1 gives exactly DEAD_CYCLES cycles in DEAD.
          if (dead_cnt <= 8'd1) begin
            dead_cnt <= '0;
            if (CONTINUOUS != 0) begin
              state <= ST_ARMED;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dead_cnt <= dead_cnt - 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_edge_decoder.sv
// Directed bench for tdc_edge_decoder: a continuous instance and a single-shot instance.
// Latency: checks hit strobes one cycle after the sampled word.
// Backpressure: not applicable.
module tb_tdc_edge_decoder;

  logic        clk100 = 1'b0;
  logic        rst;
  logic [3:0]  iser_bits;
  logic        arm;
  logic        arm_ss;

  logic        hit_valid,   hit_valid_ss;
  logic [3:0]  hit_coarse,  hit_coarse_ss;
  logic [1:0]  hit_fine,    hit_fine_ss;
  logic        coarse_wrap, coarse_wrap_ss;
  logic        busy,        busy_ss;
  logic [15:0] hit_count,   hit_count_ss;

  int n_chk = 0;
  int n_bad = 0;
  int ec    = 0;   // model of the coarse counter for the cycle about to be sampled
  int exp_c;

  always #5 clk100 = ~clk100;

  tdc_edge_decoder #(
    .SER_W(4), .COARSE_W(4), .DEAD_CYCLES(2), .CONTINUOUS(1), .CNT_W(16)
  ) dut (
    .clk100(clk100), .rst(rst), .iser_bits(iser_bits), .arm(arm),
    .hit_valid(hit_valid), .hit_coarse(hit_coarse), .hit_fine(hit_fine),
    .coarse_wrap(coarse_wrap), .busy(busy), .hit_count(hit_count)
  );

  tdc_edge_decoder #(
    .SER_W(4), .COARSE_W(4), .DEAD_CYCLES(2), .CONTINUOUS(0), .CNT_W(16)
  ) dut_ss (
    .clk100(clk100), .rst(rst), .iser_bits(iser_bits), .arm(arm_ss),
    .hit_valid(hit_valid_ss), .hit_coarse(hit_coarse_ss), .hit_fine(hit_fine_ss),
    .coarse_wrap(coarse_wrap_ss), .busy(busy_ss), .hit_count(hit_count_ss)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance the coarse model, then sample outputs 1 time unit after the edge.
  task automatic step();
    logic was_rst;
    int   prev;
    @(posedge clk100);
    was_rst = rst;
    prev    = ec;
    ec      = was_rst ? 0 : (ec + 1) % 16;
    #1;
    chk("coarse_wrap", coarse_wrap, (!was_rst && prev == 15) ? 1 : 0);
  endtask

  task automatic wait_coarse(input int v);
    int n = 0;
    while (ec != v && n < 40) begin
      step();
      n++;
    end
    chk("wait_coarse_timeout", (ec == v) ? 1 : 0, 1);
  endtask

  task automatic hit_step(input logic [3:0] w, input int fine, input int cnt);
    iser_bits = w;
    exp_c     = ec;
    step();
    chk("hit_valid", hit_valid, 1);
    chk("hit_coarse", hit_coarse, exp_c);
    chk("hit_fine", hit_fine, fine);
    chk("hit_count", hit_count, cnt);
  endtask

  task automatic nohit_step(input logic [3:0] w);
    iser_bits = w;
    step();
    chk("no_hit", hit_valid, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; arm_ss = 1'b0; iser_bits = 4'b0000;
    repeat (3) step();
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_coarse", hit_coarse, 0);
    chk("rst_hit_fine", hit_fine, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit_count", hit_count, 0);
    rst = 1'b0;

    // Basic hit at coarse 7
    arm = 1'b1;
    step();
    chk("arm_busy", busy, 1);
    arm = 1'b0;
    wait_coarse(7);
    hit_step(4'b1100, 2, 1);
    chk("dead_busy", busy, 1);
    nohit_step(4'b0000);
    chk("strobe_one_cycle", hit_valid, 0);
    nohit_step(4'b0000);
    chk("hold_coarse", hit_coarse, 7);
    chk("hold_fine", hit_fine, 2);

    // Edge straddling the word boundary; high line gives no edge
    hit_step(4'b0001, 0, 2);
    nohit_step(4'b0000);
    nohit_step(4'b1000);        // in DEAD: ignored
    nohit_step(4'b1111);        // armed, prev_last=1: no edge
    chk("no_edge_busy", busy, 1);
    chk("no_edge_count", hit_count, 2);

    // Multiple edges in one word, dead-time suppression
    nohit_step(4'b0000);
    hit_step(4'b0101, 0, 3);
    nohit_step(4'b0001);
    nohit_step(4'b0001);
    nohit_step(4'b0000);
    hit_step(4'b0001, 0, 4);
    // Edge in the first re-armed cycle is accepted
    nohit_step(4'b0000);
    nohit_step(4'b0000);
    hit_step(4'b0010, 1, 5);

    // Wrap: hit at coarse 15
    nohit_step(4'b0000);
    nohit_step(4'b0000);
    wait_coarse(15);
    hit_step(4'b0011, 0, 6);
    chk("wrap_hit_coarse", hit_coarse, 15);
    chk("wrap_pulse", coarse_wrap, 1);
    iser_bits = 4'b0000;
    step();

    // Single-shot instance
    arm_ss = 1'b1;
    step();
    chk("ss_armed_busy", busy_ss, 1);
    arm_ss = 1'b0;
    iser_bits = 4'b0100;
    exp_c = ec;
    step();
    chk("ss_hit_valid", hit_valid_ss, 1);
    chk("ss_hit_coarse", hit_coarse_ss, exp_c);
    chk("ss_hit_fine", hit_fine_ss, 2);
    chk("ss_hit_count", hit_count_ss, 1);
    iser_bits = 4'b0000;
    step();
    chk("ss_dead_busy", busy_ss, 1);
    step();
    chk("ss_idle_busy", busy_ss, 0);
    iser_bits = 4'b0001;
    step();
    chk("ss_idle_no_hit", hit_valid_ss, 0);
    iser_bits = 4'b0000;
    step();
    iser_bits = 4'b0001;
    step();
    chk("ss_idle_no_hit2", hit_valid_ss, 0);
    chk("ss_idle_count", hit_count_ss, 1);
    arm_ss = 1'b1; iser_bits = 4'b0010;
    step();
    chk("ss_arm_cycle_no_hit", hit_valid_ss, 0);
    chk("ss_rearm_busy", busy_ss, 1);
    arm_ss = 1'b0; iser_bits = 4'b0100;
    step();
    chk("ss_rearm_hit", hit_valid_ss, 1);
    chk("ss_rearm_fine", hit_fine_ss, 2);
    chk("ss_rearm_count", hit_count_ss, 2);

    // Reset in the cycle an edge is sampled while armed
    iser_bits = 4'b0000;
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; iser_bits = 4'b0001;
    step();
    chk("mid_rst_hit_valid", hit_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", hit_count, 0);
    chk("mid_rst_coarse", hit_coarse, 0);
    chk("mid_rst_fine", hit_fine, 0);
    chk("mid_rst_ss_count", hit_count_ss, 0);
    iser_bits = 4'b1111;
    step();
    rst = 1'b0;
    step();
    arm = 1'b1;
    step();
    chk("post_rst_busy", busy, 1);
    arm = 1'b0;
    nohit_step(4'b1111);
    nohit_step(4'b1111);
    chk("post_rst_count", hit_count, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
